// File: rtl/mayo_keygen_seq_if.sv
// Command, phase-unit handshake and status bundle of the MAYO keygen sequencer.
// The master modport is the sequencer side; the slave modport is the register file plus the phase units.
interface mayo_keygen_seq_if;
  logic        cfg_start;
  logic        cfg_abort;
  logic [3:0]  phase_start;
  logic [3:0]  phase_done;
  logic [3:0]  phase_err;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  err_code;
  logic [1:0]  cur_phase;
  logic [31:0] cycle_count;

  modport master (
    input  cfg_start, cfg_abort, phase_done, phase_err,
    output phase_start, busy, done, error, err_code, cur_phase, cycle_count
  );

  modport slave (
    output cfg_start, cfg_abort, phase_done, phase_err,
    input  phase_start, busy, done, error, err_code, cur_phase, cycle_count
  );
endinterface

// File: rtl/mayo_keygen_seq.sv
// Runs the four MAYO keygen phase units in order (seed expand, P1 expand, P3 compute, key pack).
// Defining KEYGEN_SEQ_WATCHDOG_EN adds the per-phase watchdog (TIMEOUT_CYCLES) and err_code 2.
module mayo_keygen_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  mayo_keygen_seq_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FAIL} state_t;
  typedef enum logic [2:0] {ERR_NONE, ERR_UNIT, ERR_TIMEOUT, ERR_ABORT} err_t;

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  err_t        err_q, err_d;
  logic [31:0] count_q;
  logic        run_clear;
  logic        busy;
  logic        unit_done;
  logic        unit_err;
  logic        timeout;

  // Only the active unit's handshake bits are observed.
  assign unit_done = bus.phase_done[phase_q];
  assign unit_err  = bus.phase_err[phase_q];
  assign busy      = (state_q == S_LAUNCH) || (state_q == S_WAIT);

`ifdef KEYGEN_SEQ_WATCHDOG_EN
  logic [15:0] wdog_q;
  logic [16:0] wdog_next;

  // wdog_next counts the WAIT cycles of this phase including the current one.
  assign wdog_next = {1'b0, wdog_q} + 17'd1;
  assign timeout   = (state_q == S_WAIT) && (wdog_next == 17'(TIMEOUT_CYCLES)) && !unit_done;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wdog_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      wdog_q <= '0;
    end else if (state_q == S_WAIT) begin
      wdog_q <= wdog_next[15:0];
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    phase_d   = phase_q;
    done_d    = done_q;
    error_d   = error_q;
    err_d     = err_q;
    run_clear = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          run_clear = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_d     = ERR_NONE;
          phase_d   = 2'd0;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (bus.cfg_abort) begin
          err_d   = ERR_ABORT;
          state_d = S_FAIL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.cfg_abort) begin
          err_d   = ERR_ABORT;
          state_d = S_FAIL;
        end else if (unit_err) begin
          err_d   = ERR_UNIT;
          state_d = S_FAIL;
        end else if (timeout) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FAIL;
        end else if (unit_done) begin
          if (phase_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            phase_d = phase_q + 2'd1;
            state_d = S_LAUNCH;
          end
        end
      end
      S_FAIL: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!ARESETN) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= ERR_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
      if (run_clear) begin
        count_q <= '0;
      end else if (busy && (count_q != '1)) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Decoded straight from registers, so the pulse is zero everywhere but LAUNCH.
  assign bus.phase_start = (state_q == S_LAUNCH) ? (4'b0001 << phase_q) : 4'b0000;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.err_code    = err_q;
  assign bus.cur_phase   = phase_q;
  assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_mayo_keygen_seq.sv
// Randomized bench for mayo_keygen_seq: scripted phase-unit responders with a run-level model
// that predicts launch order, busy-cycle totals and final status from per-phase latencies.
module tb_mayo_keygen_seq;

  logic ACLK = 1'b0;
  logic ARESETN;
  int   n_tests = 0;
  int   n_fail  = 0;

  mayo_keygen_seq_if bus ();

  mayo_keygen_seq #(.TIMEOUT_CYCLES(10)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  logic [3:0] ps_log[$];
  always @(negedge ACLK) begin
    if (bus.phase_start != 4'b0000) ps_log.push_back(bus.phase_start);
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (got running, expected finished)");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    bus.cfg_start  = 1'b0;
    bus.cfg_abort  = 1'b0;
    bus.phase_done = 4'b0000;
    bus.phase_err  = 4'b0000;
  endtask

  task automatic check_rst(input string t);
    check({t, "_phase_start"}, bus.phase_start, 0);
    check({t, "_busy"},        bus.busy, 0);
    check({t, "_done"},        bus.done, 0);
    check({t, "_error"},       bus.error, 0);
    check({t, "_err_code"},    bus.err_code, 0);
    check({t, "_cur_phase"},   bus.cur_phase, 0);
    check({t, "_cycle_count"}, bus.cycle_count, 0);
  endtask

  // stop_phase=4 means a clean run; stop_kind 1=unit error, 3=abort, 4=abort with coincident done.
  // A phase with latency L asserts its done L cycles after its start pulse.
  task automatic do_run(input int lat[4], input int stop_phase, input int stop_kind, input int stop_lat);
    int         exp_cnt;
    int         ev;
    int         n_launch;
    logic [3:0] nd, ne;
    logic [2:0] exp_code;
    exp_cnt = 0;
    ps_log.delete();
    bus.cfg_start = 1'b1;
    cyc();
    bus.cfg_start = 1'b0;
    check("start_done_clr",  bus.done, 0);
    check("start_error_clr", bus.error, 0);
    check("start_code_clr",  bus.err_code, 0);
    check("start_count_clr", bus.cycle_count, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("launch%0d_pulse", k), bus.phase_start, 4'b0001 << k);
      check($sformatf("launch%0d_busy", k),  bus.busy, 1);
      check($sformatf("launch%0d_phase", k), bus.cur_phase, k);
      ev = (k == stop_phase) ? stop_lat : lat[k];
      for (int c = 0; c <= ev; c++) begin
        exp_cnt++;
        nd = 4'($urandom) & ~(4'b0001 << k);
        ne = 4'($urandom) & ~(4'b0001 << k);
        bus.cfg_start = 1'($urandom);
        if (c == 0) nd[k] = 1'($urandom);
        if (k == 0 && c == 1 && c < ev) begin
          nd[3] = 1'b1;
          bus.cfg_start = 1'b1;
        end
        if (c == ev) begin
          if (k != stop_phase) begin
            nd[k] = 1'b1;
          end else begin
            case (stop_kind)
              1: begin ne[k] = 1'b1; nd[k] = 1'($urandom); end
              3: bus.cfg_abort = 1'b1;
              default: begin bus.cfg_abort = 1'b1; nd[k] = 1'b1; end
            endcase
          end
        end
        bus.phase_done = nd;
        bus.phase_err  = ne;
        cyc();
        idle_inputs();
        if (c < ev) begin
          check($sformatf("wait%0d_busy", k),  bus.busy, 1);
          check($sformatf("wait%0d_pulse", k), bus.phase_start, 0);
          check($sformatf("wait%0d_phase", k), bus.cur_phase, k);
        end
      end
      if (k == stop_phase) begin
        exp_code = (stop_kind == 1) ? 3'd1 : 3'd3;
        check("fail_busy_low", bus.busy, 0);
        check("fail_no_pulse", bus.phase_start, 0);
        cyc();
        check("fail_error",     bus.error, 1);
        check("fail_err_code",  bus.err_code, exp_code);
        check("fail_done",      bus.done, 0);
        check("fail_cur_phase", bus.cur_phase, k);
        check("fail_count",     bus.cycle_count, exp_cnt);
        break;
      end
      if (k == 3) begin
        check("end_busy",      bus.busy, 0);
        check("end_done",      bus.done, 1);
        check("end_error",     bus.error, 0);
        check("end_err_code",  bus.err_code, 0);
        check("end_cur_phase", bus.cur_phase, 3);
        check("end_count",     bus.cycle_count, exp_cnt);
      end
    end
    n_launch = (stop_phase < 4) ? stop_phase + 1 : 4;
    cyc();
    cyc();
    check("launch_log_len", ps_log.size(), n_launch);
    for (int i = 0; i < n_launch && i < ps_log.size(); i++)
      check($sformatf("launch_log%0d", i), ps_log[i], 4'b0001 << i);
  endtask

  initial begin
    int lat[4];
    int sp, kind, sl, r, nbusy;
    idle_inputs();
    ARESETN = 1'b0;
    #1;
    check_rst("reset");
    repeat (2) cyc();
    ARESETN = 1'b1;
    cyc();

    lat = '{3, 3, 3, 3};
    do_run(lat, 4, 0, 0);
    lat = '{1, 1, 1, 1};
    do_run(lat, 4, 0, 0);
    lat = '{3, 3, 3, 3};
    do_run(lat, 2, 1, 2);
    lat = '{2, 2, 2, 2};
    do_run(lat, 1, 4, 2);
    lat = '{4, 2, 3, 1};
    do_run(lat, 4, 0, 0);

    for (int n = 0; n < 8; n++) begin
      foreach (lat[i]) lat[i] = $urandom_range(1, 6);
      do_run(lat, 4, 0, 0);
      sp   = $urandom_range(0, 3);
      r    = $urandom_range(0, 2);
      kind = (r == 0) ? 1 : ((r == 1) ? 3 : 4);
      sl   = (kind == 1) ? $urandom_range(1, 5) : $urandom_range(0, 5);
      do_run(lat, sp, kind, sl);
    end

    // Unit 0 never answers.
    bus.cfg_start = 1'b1;
    cyc();
    bus.cfg_start = 1'b0;
    check("wd_launch", bus.phase_start, 1);
    nbusy = 1;
`ifdef KEYGEN_SEQ_WATCHDOG_EN
    for (int i = 0; i < 50 && bus.busy; i++) begin
      cyc();
      if (bus.busy) nbusy++;
    end
    check("wd_busy_cycles", nbusy, 11);
    check("wd_count", bus.cycle_count, 11);
    cyc();
    check("wd_error", bus.error, 1);
    check("wd_err_code", bus.err_code, 2);
`else
    for (int i = 1; i < 1000; i++) begin
      cyc();
      if (bus.busy) nbusy++;
    end
    check("nowd_busy_cycles", nbusy, 1000);
    bus.cfg_abort = 1'b1;
    cyc();
    bus.cfg_abort = 1'b0;
    check("nowd_abort_busy", bus.busy, 0);
    cyc();
    check("nowd_err_code", bus.err_code, 3);
    check("nowd_count", bus.cycle_count, 1000);
`endif
    cyc();

    // Asynchronous reset in the middle of phase 1.
    bus.cfg_start = 1'b1;
    cyc();
    bus.cfg_start = 1'b0;
    cyc();
    bus.phase_done = 4'b0001;
    cyc();
    bus.phase_done = 4'b0000;
    cyc();
    check("pre_rst_busy",  bus.busy, 1);
    check("pre_rst_phase", bus.cur_phase, 1);
    #2 ARESETN = 1'b0;
    #1 check_rst("mid_rst");
    cyc();
    check_rst("rst_hold");
    ARESETN = 1'b1;
    ps_log.delete();
    repeat (3) cyc();
    check("post_rst_no_pulse", ps_log.size(), 0);
    check("post_rst_busy", bus.busy, 0);

    lat = '{2, 3, 1, 2};
    do_run(lat, 4, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
